// File: rtl/riscv_pkg.sv
// Shared encodings for the boot loader / instruction memory block.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/imem_rd_pipe.sv
// Fetch response shift stage: RD_LAT registered valid/err/data stages.
// Data and err of a stage only move when the stage feeding it is valid.
module imem_rd_pipe #(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_err,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    output logic            out_err,
    output logic [XLEN-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [XLEN-1:0]   data_q [RD_LAT];
    logic [XLEN-1:0]   data_d [RD_LAT];

    always_comb begin
        vld_d     = vld_q;
        err_d     = err_q;
        data_d    = data_q;
        vld_d[0]  = in_valid;
        err_d[0]  = in_valid ? in_err  : err_q[0];
        data_d[0] = in_valid ? in_data : data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = vld_q[i-1] ? err_q[i-1]  : err_q[i];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '{default: '0};
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/boot_imem_ctrl.sv
// Boot loader and instruction memory: streams a program in, holds the CPU in
// reset, then serves pipelined fetches from the loaded image.
//
// state   | meaning
// ST_LOAD | accepting program words; CPU held in reset
// ST_HOLD | image complete; CPU held in reset for HOLD_CYC+1 cycles
// ST_RUN  | CPU released; fetches served; run_cycles counting
module boot_imem_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int HOLD_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [XLEN-1:0]          ld_data,
    input  logic                     ld_last,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_valid,
    output logic [XLEN-1:0]          fetch_data,
    output logic                     fetch_err,
    output logic                     cpu_reset,
    output logic [$clog2(DEPTH):0]   prog_words,
    output logic [31:0]              run_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (ADDR_W - 2 > PW) ? ADDR_W - 2 : PW;

    state_e          state_q, state_d;
    logic            ld_ready_q, ld_ready_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic [PW-1:0]   words_q, words_d;
    logic [31:0]     run_q, run_d;
    logic [7:0]      hold_q, hold_d;

    logic [XLEN-1:0] mem [DEPTH];
    logic            ld_fire;
    logic            last_word;
    logic [ADDR_W-3:0] fetch_idx;
    logic            rd_valid;
    logic            rd_err;
    logic [XLEN-1:0] rd_data;

    assign ld_fire   = ld_valid && ld_ready_q;
    // The word landing in the last slot closes the image even without ld_last.
    assign last_word = ld_last || (words_q == PW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        run_d   = run_q;
        hold_d  = hold_q;
        case (state_q)
            ST_LOAD: begin
                if (ld_fire) begin
                    words_d = words_q + PW'(1);
                    if (last_word) begin
                        state_d = ST_HOLD;
                        hold_d  = 8'(HOLD_CYC);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            ST_RUN: begin
                if (run_q != 32'hFFFF_FFFF) begin
                    run_d = run_q + 32'd1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        ld_ready_d  = (state_d == ST_LOAD);
        cpu_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            ld_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            words_q     <= '0;
            run_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            ld_ready_q  <= ld_ready_d;
            cpu_reset_q <= cpu_reset_d;
            words_q     <= words_d;
            run_q       <= run_d;
            hold_q      <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[words_q[AW-1:0]] <= ld_data;
        end
    end

    assign fetch_idx = fetch_addr[ADDR_W-1:2];

    always_comb begin
        rd_valid = fetch_req && (state_q == ST_RUN);
        rd_err   = (fetch_addr[1:0] != 2'b00) || (CW'(fetch_idx) >= CW'(words_q));
        rd_data  = rd_err ? XLEN'(NOP_INST) : mem[fetch_idx[AW-1:0]];
    end

    imem_rd_pipe #(
        .XLEN   (XLEN),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (rd_valid),
        .in_err    (rd_err),
        .in_data   (rd_data),
        .out_valid (fetch_valid),
        .out_err   (fetch_err),
        .out_data  (fetch_data)
    );

    assign ld_ready   = ld_ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign prog_words = words_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_boot_imem_ctrl.sv
// Bench for boot_imem_ctrl: two instances (DEPTH=256/RD_LAT=2/HOLD_CYC=4 and
// DEPTH=4/RD_LAT=1/HOLD_CYC=0) checked every cycle against a queue-based model.
module tb_boot_imem_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       ld_valid, ld_last, fetch_req;
    logic [1:0][31:0] ld_data, fetch_addr;
    logic [1:0]       ld_ready, fetch_valid, fetch_err, cpu_reset;
    logic [1:0][31:0] fetch_data, run_cycles;
    logic [8:0]       pw0;
    logic [2:0]       pw1;

    int errors = 0;
    int checks = 0;

    boot_imem_ctrl #(.XLEN(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(2), .HOLD_CYC(4)) dut0 (
        .clk(clk), .reset(rst_n),
        .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]), .ld_data(ld_data[0]), .ld_last(ld_last[0]),
        .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
        .fetch_valid(fetch_valid[0]), .fetch_data(fetch_data[0]), .fetch_err(fetch_err[0]),
        .cpu_reset(cpu_reset[0]), .prog_words(pw0), .run_cycles(run_cycles[0])
    );

    boot_imem_ctrl #(.XLEN(32), .DEPTH(4), .ADDR_W(32), .RD_LAT(1), .HOLD_CYC(0)) dut1 (
        .clk(clk), .reset(rst_n),
        .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]), .ld_data(ld_data[1]), .ld_last(ld_last[1]),
        .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
        .fetch_valid(fetch_valid[1]), .fetch_data(fetch_data[1]), .fetch_err(fetch_err[1]),
        .cpu_reset(cpu_reset[1]), .prog_words(pw1), .run_cycles(run_cycles[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int dep(input int k);   return (k == 0) ? 256 : 4; endfunction
    function automatic int lat(input int k);   return (k == 0) ? 2 : 1;   endfunction
    function automatic int hcyc(input int k);  return (k == 0) ? 4 : 0;   endfunction

    typedef struct { int k; int due; logic err; logic [31:0] data; } fq_t;
    fq_t         fq[$];
    int          ph[2], nw[2], hel[2], cyc[2];
    logic [31:0] rc[2];
    logic        e_rdy[2], e_cpr[2], e_vld[2], e_err[2];
    logic [31:0] e_dat[2];
    logic [31:0] mm[2][256];

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; nw[k] = 0; hel[k] = 0; cyc[k] = 0; rc[k] = 0;
            e_rdy[k] = 1'b0; e_cpr[k] = 1'b1; e_vld[k] = 1'b0; e_err[k] = 1'b0; e_dat[k] = '0;
        end
        fq.delete();
    endtask

    // phases: 0 = loading, 1 = holding, 2 = running
    task automatic mstep(input int k);
        int          idx;
        logic        err;
        logic [31:0] d;
        if (ph[k] == 2 && fetch_req[k]) begin
            idx = int'(fetch_addr[k] >> 2);
            err = (fetch_addr[k][1:0] != 2'b00) || (idx >= nw[k]);
            d   = NOP;
            if (!err) d = mm[k][idx];
            fq.push_back('{k, cyc[k] + lat(k), err, d});
        end
        if (ph[k] == 0) begin
            if (ld_valid[k] && e_rdy[k]) begin
                mm[k][nw[k]] = ld_data[k];
                nw[k]++;
                if (ld_last[k] || nw[k] == dep(k)) begin ph[k] = 1; hel[k] = 0; end
            end
        end else if (ph[k] == 1) begin
            hel[k]++;
            if (hel[k] == hcyc(k) + 1) ph[k] = 2;
        end else if (rc[k] != 32'hFFFF_FFFF) begin
            rc[k]++;
        end
        cyc[k]++;
        e_rdy[k] = (ph[k] == 0);
        e_cpr[k] = (ph[k] != 2);
        e_vld[k] = 1'b0;
        for (int i = 0; i < fq.size(); i++) begin
            if (fq[i].k == k) begin
                if (fq[i].due == cyc[k]) begin
                    e_vld[k] = 1'b1; e_err[k] = fq[i].err; e_dat[k] = fq[i].data;
                    fq.delete(i);
                end
                break;
            end
        end
    endtask

    always @(posedge clk) if (rst_n) begin mstep(0); mstep(1); end
    always @(negedge rst_n) mreset();

    function automatic int dut_words(input int k);
        return (k == 0) ? int'(pw0) : int'(pw1);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ld_ready%0d", k),    64'(ld_ready[k]),    64'(e_rdy[k]));
            chk($sformatf("cpu_reset%0d", k),   64'(cpu_reset[k]),   64'(e_cpr[k]));
            chk($sformatf("prog_words%0d", k),  64'(dut_words(k)),   64'(nw[k]));
            chk($sformatf("run_cycles%0d", k),  64'(run_cycles[k]),  64'(rc[k]));
            chk($sformatf("fetch_valid%0d", k), 64'(fetch_valid[k]), 64'(e_vld[k]));
            chk($sformatf("fetch_err%0d", k),   64'(fetch_err[k]),   64'(e_err[k]));
            chk($sformatf("fetch_data%0d", k),  64'(fetch_data[k]),  64'(e_dat[k]));
        end
    end

    int early_vld = 0;
    always @(negedge clk) if (cpu_reset[0] && fetch_valid[0]) early_vld++;

    // ---------------- stimulus ----------------
    logic [31:0] fa[8];
    logic [33:0] rec[8];
    logic [31:0] w[4], v[4], x[2];

    task automatic load_word(input int k, input logic [31:0] d, input logic last,
                             input bit rnd, output logic hs);
        int budget;
        if (rnd) begin
            while ($urandom_range(0, 2) == 0) begin
                ld_valid[k] = 1'b0;
                ld_data[k]  = $urandom;
                ld_last[k]  = 1'($urandom_range(0, 1));
                fetch_req[k]  = 1'b1;
                fetch_addr[k] = 32'($urandom_range(0, 63));
                @(posedge clk); #1;
            end
        end
        ld_valid[k] = 1'b1;
        ld_data[k]  = d;
        ld_last[k]  = last;
        hs = 1'b0;
        budget = 0;
        while (!hs && budget < 8) begin
            hs = ld_ready[k];
            @(posedge clk); #1;
            budget++;
        end
        ld_valid[k] = 1'b0;
        ld_last[k]  = 1'b0;
    endtask

    task automatic wait_release(input int k, output int n);
        n = 0;
        while (cpu_reset[k] && n < 20) begin @(posedge clk); #1; n++; end
        fetch_req[k] = 1'b0;
    endtask

    task automatic fetch_run(input int k, input int na);
        for (int i = 0; i < 8; i++) begin
            fetch_req[k]  = (i < na);
            fetch_addr[k] = (i < na) ? fa[i] : 32'h0;
            @(posedge clk); #1;
            rec[i] = {fetch_valid[k], fetch_err[k], fetch_data[k]};
        end
        fetch_req[k] = 1'b0;
    endtask

    initial begin
        logic hs;
        int   n;
        w = '{32'h0050_0093, 32'h0010_8113, 32'h0020_81b3, 32'h0000_006f};
        v = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        x = '{32'hcafe_0001, 32'hcafe_0002};
        mreset();
        rst_n = 1'b0;
        ld_valid = '0; ld_last = '0; fetch_req = '0;
        ld_data = '0; fetch_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", 64'(cpu_reset[0]), 64'd1);
        chk("rst_ld_ready",  64'(ld_ready[0]),  64'd0);
        chk("rst_words",     64'(pw0),          64'd0);
        rst_n = 1'b1;

        // load 4 words with random gaps and fetches during LOAD/HOLD
        fetch_req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_word(0, w[i], (i == 3), 1'b1, hs);
            chk("t1_handshake", 64'(hs), 64'd1);
        end
        wait_release(0, n);
        chk("t1_hold_len",   64'(n),             64'd5);
        chk("t1_prog_words", 64'(pw0),           64'd4);
        chk("t1_ready_off",  64'(ld_ready[0]),   64'd0);
        chk("t1_run0",       64'(run_cycles[0]), 64'd0);
        chk("t5_no_early",   64'(early_vld),     64'd0);

        // back-to-back fetches, two-cycle latency
        fa = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        fetch_run(0, 3);
        chk("t2_r0", 64'(rec[0][33]), 64'd0);
        chk("t2_r1", 64'(rec[1]), 64'({2'b10, w[0]}));
        chk("t2_r2", 64'(rec[2]), 64'({2'b10, w[1]}));
        chk("t2_r3", 64'(rec[3]), 64'({2'b10, w[2]}));
        chk("t2_r4", 64'(rec[4]), 64'({2'b00, w[2]}));

        // misaligned, beyond image, and last valid word
        fa = '{32'h6, 32'h10, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        fetch_run(0, 3);
        chk("t3_misaligned", 64'(rec[1]), 64'({2'b11, NOP}));
        chk("t3_beyond",     64'(rec[2]), 64'({2'b11, NOP}));
        chk("t3_last_word",  64'(rec[3]), 64'({2'b10, w[3]}));

        // depth-limited load on the DEPTH=4 instance, no ld_last
        for (int i = 0; i < 4; i++) begin
            load_word(1, v[i], 1'b0, 1'b0, hs);
            chk("t4_handshake", 64'(hs), 64'd1);
        end
        chk("t4_ready_off", 64'(ld_ready[1]), 64'd0);
        wait_release(1, n);
        chk("t4_hold_len", 64'(n), 64'd1);
        load_word(1, 32'hbad0_bad0, 1'b1, 1'b0, hs);
        chk("t4_5th_rejected", 64'(hs),  64'd0);
        chk("t4_prog_words",   64'(pw1), 64'd4);
        fa = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h0, 32'h0, 32'h0};
        fetch_run(1, 5);
        chk("t4_r0", 64'(rec[0]), 64'({2'b10, v[0]}));
        chk("t4_r3", 64'(rec[3]), 64'({2'b10, v[3]}));
        chk("t4_r4", 64'(rec[4]), 64'({2'b11, NOP}));
        chk("t4_r5", 64'(rec[5]), 64'({2'b01, NOP}));

        // reset mid-RUN with fetches in the pipeline
        fetch_req[0] = 1'b1; fetch_addr[0] = 32'h0;
        @(posedge clk); #1;
        fetch_addr[0] = 32'h4;
        @(posedge clk); #1;
        chk("t6_pre_valid", 64'(fetch_valid[0]), 64'd1);
        fetch_req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_valid",     64'(fetch_valid[0]), 64'd0);
        chk("t6_cpu_reset", 64'(cpu_reset[0]),   64'd1);
        chk("t6_run",       64'(run_cycles[0]),  64'd0);
        chk("t6_words",     64'(pw0),            64'd0);
        chk("t6_data",      64'(fetch_data[0]),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // reload starts at word 0
        load_word(0, x[0], 1'b0, 1'b0, hs);
        chk("t6_reload0", 64'(hs), 64'd1);
        load_word(0, x[1], 1'b1, 1'b0, hs);
        chk("t6_reload1", 64'(hs), 64'd1);
        wait_release(0, n);
        chk("t6_hold_len", 64'(n), 64'd5);
        fa = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        fetch_run(0, 3);
        chk("t6_f0", 64'(rec[1]), 64'({2'b10, x[0]}));
        chk("t6_f1", 64'(rec[2]), 64'({2'b10, x[1]}));
        chk("t6_f2", 64'(rec[3]), 64'({2'b11, NOP}));
        chk("t6_no_early", 64'(early_vld), 64'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
